// File: rtl/montred_pkg.sv
// rtl/montred_pkg.sv - shared state type, sizing helper and default moduli for the Montgomery reducer
package montred_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ITER,
      S_CORR,
      S_DONE
   } state_t;

   localparam logic [63:0] DEF_Q  = 64'hFFFF_FFFF_0000_0001;
   localparam logic [15:0] DEF_QP = 16'hFFFF;

   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

endpackage

// File: rtl/montred_step.sv
// rtl/montred_step.sv - one word-serial Montgomery step: T_next = (T + m*Q) >> WW
module montred_step #(
   parameter int W  = 64,
   parameter int WW = 16
) (
   input  logic [2*W:0]  t,
   input  logic [W-1:0]  q,
   input  logic [WW-1:0] qp,
   output logic [2*W:0]  t_next
);
   localparam int TW = 2*W + 1;
   localparam int SW = 2*W + WW + 1;

   logic [WW-1:0] m;
   logic [SW-1:0] sum;

   // m is chosen so the low WW bits of the sum cancel to zero
   assign m      = t[WW-1:0] * qp;
   assign sum    = SW'(t) + SW'(m) * SW'(q);
   assign t_next = TW'(sum >> WW);

endmodule

// File: rtl/montred_wordserial.sv
// rtl/montred_wordserial.sv - word-serial Montgomery reduction Z = C*R^-1 mod Q
// Define MONTRED_FAST_RDY_EN to accept a new operand in the cycle a result is taken.
module montred_wordserial
   import montred_pkg::*;
#(
   parameter int            W  = 64,
   parameter int            WW = 16,
   parameter logic [W-1:0]  Q  = W'(DEF_Q),
   parameter logic [WW-1:0] QP = WW'(DEF_QP)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [2*W-1:0] in_data,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W-1:0]   out_data,
   output logic           busy
);
   localparam int N  = ceil_div(W, WW);
   localparam int TW = 2*W + 1;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [TW-1:0] Q_EXT = TW'(Q);

   state_t        state, state_nxt;
   logic [TW-1:0] t_q, t_step;
   logic [CW-1:0] cnt_q;
   logic          accept, last_iter;

   montred_step #(.W(W), .WW(WW)) u_step (
      .t      (t_q),
      .q      (Q),
      .qp     (QP),
      .t_next (t_step)
   );

   assign last_iter = (cnt_q == CW'(N - 1));
   assign accept    = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      case (state)
         S_IDLE: begin
            in_ready = ~rst;
            if (in_valid) state_nxt = S_ITER;
         end
         S_ITER: if (last_iter) state_nxt = S_CORR;
         S_CORR: state_nxt = S_DONE;
         S_DONE: begin
`ifdef MONTRED_FAST_RDY_EN
            in_ready = ~rst & out_ready;
            if (out_ready) state_nxt = in_valid ? S_ITER : S_IDLE;
`else
            if (out_ready) state_nxt = S_IDLE;
`endif
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // T enters CORR below 2Q, so one conditional subtract lands it in [0, Q)
   always_ff @(posedge clk) begin
      if (rst) begin
         t_q   <= '0;
         cnt_q <= '0;
      end else if (accept) begin
         t_q   <= TW'(in_data);
         cnt_q <= '0;
      end else begin
         case (state)
            S_ITER: begin
               t_q   <= t_step;
               cnt_q <= cnt_q + CW'(1);
            end
            S_CORR: if (t_q >= Q_EXT) t_q <= t_q - Q_EXT;
            default: ;
         endcase
      end
   end

   assign out_valid = (state == S_DONE);
   assign out_data  = out_valid ? t_q[W-1:0] : '0;
   assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_montred_wordserial.sv
// tb/tb_montred_wordserial.sv - directed and random bench for montred_wordserial (W=16, WW=8, Q=FFF1)
module tb_montred_wordserial;

   localparam int NRAND = 1000;
   localparam int NTP   = 8;
`ifdef MONTRED_FAST_RDY_EN
   localparam int EXP_IVL = 4;
`else
   localparam int EXP_IVL = 5;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   logic [31:0] dir_c [3] = '{32'h0001_0000, 32'h0000_FFF1, 32'hFFF0_FFFF};
   logic [15:0] dir_z [3] = '{16'h0001,      16'h0000,      16'h1110};

   always #5 clk = ~clk;

   montred_wordserial #(
      .W  (16),
      .WW (8),
      .Q  (16'hFFF1),
      .QP (8'hEF)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   // R mod Q = 15, so R^-1 mod 65521 = 61153
   function automatic logic [15:0] ref_z(input logic [31:0] c);
      logic [63:0] x;
      x = 64'(c) % 64'd65521;
      x = (x * 64'd61153) % 64'd65521;
      return x[15:0];
   endfunction

   function automatic logic [31:0] rand_c();
      logic [31:0] r;
      r = $urandom;
      return r % 32'hFFF1_0000;
   endfunction

   task automatic accept_op(input logic [31:0] c, output bit ok);
      bit rdy;
      ok       = 1'b0;
      in_data  = c;
      in_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         rdy = in_ready;
         @(posedge clk);
         #1;
         if (rdy) begin
            ok = 1'b1;
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   // Called in cycle k+1; returns j such that out_valid first rises in cycle k+j
   task automatic wait_valid(output int lat);
      lat = -1;
      if (out_valid) begin
         lat = 1;
         return;
      end
      for (int i = 1; i <= 50; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) begin
            lat = i + 1;
            return;
         end
      end
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++;
      if (out_data !== 16'h0000) begin failures++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL first_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_directed();
      bit ok;
      int lat;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         accept_op(dir_c[i], ok);
         checks++;
         if (!ok) begin failures++; $display("FAIL dir%0d_accept got=timeout exp=accept", i); end
         wait_valid(lat);
         checks++;
         if (lat != 4) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=4", i, lat); end
         checks++;
         if (out_data !== dir_z[i]) begin failures++; $display("FAIL dir%0d_data got=%h exp=%h", i, out_data, dir_z[i]); end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      int lat;
      out_ready = 1'b0;
      accept_op(32'h0001_0000, ok);
      wait_valid(lat);
      checks++;
      if (!ok || lat != 4) begin failures++; $display("FAIL bp_latency got=%0d exp=4", lat); end
      for (int i = 0; i < 5; i++) begin
         in_data  = 32'h1234_5678;
         in_valid = 1'b1;
         @(posedge clk);
         #1;
         checks++;
         if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid%0d got=%b exp=1", i, out_valid); end
         checks++;
         if (out_data !== 16'h0001) begin failures++; $display("FAIL bp_data%0d got=%h exp=0001", i, out_data); end
         checks++;
         if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready%0d got=%b exp=0", i, in_ready); end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL bp_release got=valid%b/busy%b exp=valid0/busy0", out_valid, busy);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      bit seen;
      int lat;
      out_ready = 1'b1;
      accept_op(32'h0001_0000, ok);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (out_valid) seen = 1'b1;
         @(posedge clk);
         #1;
      end
      checks++;
      if (seen) begin failures++; $display("FAIL rstmid_stale_valid got=1 exp=0"); end
      accept_op(32'hFFF0_FFFF, ok);
      wait_valid(lat);
      checks++;
      if (!ok || lat != 4) begin failures++; $display("FAIL rstmid_latency got=%0d exp=4", lat); end
      checks++;
      if (out_data !== 16'h1110) begin failures++; $display("FAIL rstmid_data got=%h exp=1110", out_data); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_throughput();
      logic [15:0] exp_q[$];
      logic [15:0] e;
      int n_acc, n_out, cyc, last_acc;
      bit acc, fire;
      n_acc    = 0;
      n_out    = 0;
      cyc      = 0;
      last_acc = -1;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      in_data   = rand_c();
      in_valid  = 1'b1;
      #1;
      while (n_out < NTP && cyc < 400) begin
         acc  = in_valid && in_ready;
         fire = out_valid && out_ready;
         if (fire) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL tp_extra_output got=%h exp=none", out_data);
            end else begin
               e = exp_q.pop_front();
               if (out_data !== e) begin failures++; $display("FAIL tp_data%0d got=%h exp=%h", n_out, out_data, e); end
            end
            n_out++;
         end
         if (acc) begin
            exp_q.push_back(ref_z(in_data));
            if (last_acc >= 0) begin
               checks++;
               if (cyc - last_acc != EXP_IVL) begin
                  failures++;
                  $display("FAIL tp_interval%0d got=%0d exp=%0d", n_acc, cyc - last_acc, EXP_IVL);
               end
            end
            last_acc = cyc;
            n_acc++;
         end
         @(posedge clk);
         #1;
         cyc++;
         if (acc) begin
            if (n_acc < NTP) in_data = rand_c();
            else             in_valid = 1'b0;
         end
         #1;
      end
      checks++;
      if (n_out != NTP) begin failures++; $display("FAIL tp_timeout got=%0d exp=%0d", n_out, NTP); end
      in_valid = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp_q[$];
      logic [15:0] e;
      int n_acc, n_out, cyc;
      bit acc, fire;
      n_acc = 0;
      n_out = 0;
      cyc   = 0;
      @(posedge clk);
      #1;
      in_data   = rand_c();
      in_valid  = 1'b1;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      while (n_out < NRAND && cyc < 20000) begin
         acc  = in_valid && in_ready;
         fire = out_valid && out_ready;
         if (fire) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL b2b_extra_output got=%h exp=none", out_data);
            end else begin
               e = exp_q.pop_front();
               if (out_data !== e) begin failures++; $display("FAIL b2b_data%0d got=%h exp=%h", n_out, out_data, e); end
            end
            n_out++;
         end
         if (acc) begin
            exp_q.push_back(ref_z(in_data));
            n_acc++;
         end
         @(posedge clk);
         #1;
         cyc++;
         if (acc) begin
            if (n_acc < NRAND) in_data = rand_c();
            else               in_valid = 1'b0;
         end
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
      end
      checks++;
      if (n_out != NRAND) begin failures++; $display("FAIL b2b_timeout got=%0d exp=%0d", n_out, NRAND); end
      in_valid  = 1'b0;
      out_ready = 1'b1;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid();
      test_throughput();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
